// File: rtl/prog_clock_div_pkg.sv
// Shared types for the programmable multi-channel clock divider.
// Output mode encoding plus the helper that advances an output level at a terminal count.
package prog_clock_div_pkg;

    typedef enum logic {
        MODE_CLOCK  = 1'b0,
        MODE_STROBE = 1'b1
    } mode_e;

    // Output level after a terminal count that does not change the mode.
    function automatic logic next_level(input mode_e mode, input logic level);
        return (mode == MODE_STROBE) ? 1'b1 : ~level;
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: counter, active/shadow ratio+mode, registered out/tick/pending.
// Shadow config is only promoted at a terminal count, on sync, or while disabled.
module clock_div_chan
    import prog_clock_div_pkg::*;
#(
    parameter int unsigned      DIV_W        = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV  = '0,
    parameter mode_e            DEFAULT_MODE = MODE_CLOCK
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sync,
    input  logic           wr,
    input  logic [DIV_W:0] wdata,
    output logic           out,
    output logic           tick,
    output logic           pending
);

    typedef struct packed {
        mode_e            mode;
        logic [DIV_W-1:0] div;
    } chan_cfg_t;

    localparam chan_cfg_t DEFAULT_CFG = '{mode: DEFAULT_MODE, div: DEFAULT_DIV};

    chan_cfg_t        act_cfg;
    chan_cfg_t        shd_cfg;
    chan_cfg_t        wr_cfg;
    logic [DIV_W-1:0] cnt;
    logic             terminal;
    logic             mode_change;

    assign wr_cfg      = chan_cfg_t'(wdata);
    assign terminal    = (cnt == act_cfg.div);
    assign mode_change = pending && (shd_cfg.mode != act_cfg.mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            act_cfg <= DEFAULT_CFG;
            shd_cfg <= DEFAULT_CFG;
            pending <= 1'b0;
            out     <= 1'b0;
            tick    <= 1'b0;
        end else if (sync || !en) begin
            cnt     <= '0;
            out     <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            // A write in this cycle lands after the apply, so it wins outright.
            if (wr) begin
                act_cfg <= wr_cfg;
                shd_cfg <= wr_cfg;
            end else begin
                act_cfg <= shd_cfg;
            end
        end else begin
            if (terminal) begin
                cnt  <= '0;
                tick <= 1'b1;
                if (pending) begin
                    act_cfg <= shd_cfg;
                    pending <= 1'b0;
                end
                // A mode switch parks the output low for this one boundary.
                if (mode_change) begin
                    out <= 1'b0;
                end else begin
                    out <= next_level(act_cfg.mode, out);
                end
            end else begin
                cnt  <= cnt + DIV_W'(1);
                tick <= 1'b0;
                if (act_cfg.mode == MODE_STROBE) begin
                    out <= 1'b0;
                end
            end
            // Terminal above consumed the old shadow; this write waits for the next one.
            if (wr) begin
                shd_cfg <= wr_cfg;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_clock_div.sv
// Multi-channel programmable clock/strobe divider with glitch-free shadowed reconfiguration.
// The top only decodes the config channel select and fans out to per-channel dividers.
module prog_clock_div
    import prog_clock_div_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned DEFAULT_DIV  = 0,
    parameter int unsigned DEFAULT_MODE = 0
) (
    input  logic                                          clock_in_i,
    input  logic                                          reset_i,
    input  logic [NUM_CH-1:0]                             en_i,
    input  logic                                          sync_i,
    input  logic                                          cfg_we_i,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
    input  logic [DIV_W-1:0]                              cfg_div_i,
    input  logic                                          cfg_mode_i,
    output logic [NUM_CH-1:0]                             clock_out_o,
    output logic [NUM_CH-1:0]                             tick_o,
    output logic [NUM_CH-1:0]                             cfg_pending_o
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam mode_e RESET_MODE = (DEFAULT_MODE != 0) ? MODE_STROBE : MODE_CLOCK;

    logic             ch_ok;
    logic [DIV_W:0]   wdata;
    logic [NUM_CH-1:0] wr;

    // Selects beyond the last channel are dropped (reachable when NUM_CH is not a power of two).
    assign ch_ok = (32'(cfg_ch_i) < NUM_CH);
    assign wdata = {cfg_mode_i, cfg_div_i};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign wr[g] = cfg_we_i && ch_ok && (cfg_ch_i == CH_W'(g));

        clock_div_chan #(
            .DIV_W        (DIV_W),
            .DEFAULT_DIV  (DIV_W'(DEFAULT_DIV)),
            .DEFAULT_MODE (RESET_MODE)
        ) u_chan (
            .clk     (clock_in_i),
            .rst     (reset_i),
            .en      (en_i[g]),
            .sync    (sync_i),
            .wr      (wr[g]),
            .wdata   (wdata),
            .out     (clock_out_o[g]),
            .tick    (tick_o[g]),
            .pending (cfg_pending_o[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_div.sv
// Scoreboard bench for prog_clock_div: directed scenarios plus random traffic against a
// countdown-based reference model; a monitor pops expected outputs every falling edge.
module tb_prog_clock_div;

    localparam int NCH = 4;

    logic           clock_in_i = 1'b0;
    logic           reset_i;
    logic [NCH-1:0] en_i;
    logic           sync_i;
    logic           cfg_we_i;
    logic [1:0]     cfg_ch_i;
    logic [15:0]    cfg_div_i;
    logic           cfg_mode_i;
    logic [NCH-1:0] clock_out_o;
    logic [NCH-1:0] tick_o;
    logic [NCH-1:0] cfg_pending_o;

    prog_clock_div dut (
        .clock_in_i    (clock_in_i),
        .reset_i       (reset_i),
        .en_i          (en_i),
        .sync_i        (sync_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_ch_i      (cfg_ch_i),
        .cfg_div_i     (cfg_div_i),
        .cfg_mode_i    (cfg_mode_i),
        .clock_out_o   (clock_out_o),
        .tick_o        (tick_o),
        .cfg_pending_o (cfg_pending_o)
    );

    always #5 clock_in_i = ~clock_in_i;

    typedef struct packed {
        logic [NCH-1:0] out;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: edges remaining until the next terminal, plus active/shadow settings.
    int unsigned a_div[NCH];
    int unsigned s_div[NCH];
    int unsigned rem[NCH];
    bit          a_mode[NCH];
    bit          s_mode[NCH];
    bit          pend[NCH];
    bit          lvl[NCH];
    bit          tk[NCH];

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            a_div[c] = 0; s_div[c] = 0; a_mode[c] = 0; s_mode[c] = 0;
            pend[c] = 0; lvl[c] = 0; tk[c] = 0; rem[c] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NCH; c++) begin
            bit w;
            bit changed;
            w = cfg_we_i && (int'(cfg_ch_i) == c);
            if (sync_i || !en_i[c]) begin
                if (w) begin
                    a_div[c] = cfg_div_i; a_mode[c] = cfg_mode_i;
                end else begin
                    a_div[c] = s_div[c]; a_mode[c] = s_mode[c];
                end
                s_div[c] = a_div[c]; s_mode[c] = a_mode[c];
                pend[c] = 0; lvl[c] = 0; tk[c] = 0;
                rem[c] = a_div[c];
            end else begin
                if (rem[c] == 0) begin
                    tk[c] = 1;
                    changed = 0;
                    if (pend[c]) begin
                        changed = (s_mode[c] != a_mode[c]);
                        a_div[c] = s_div[c]; a_mode[c] = s_mode[c];
                        pend[c] = 0;
                    end
                    if (changed) lvl[c] = 0;
                    else if (a_mode[c]) lvl[c] = 1;
                    else lvl[c] = !lvl[c];
                    rem[c] = a_div[c];
                end else begin
                    rem[c] = rem[c] - 1;
                    tk[c] = 0;
                    if (a_mode[c]) lvl[c] = 0;
                end
                if (w) begin
                    s_div[c] = cfg_div_i; s_mode[c] = cfg_mode_i; pend[c] = 1;
                end
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            e.out[c]  = lvl[c];
            e.tick[c] = tk[c];
            e.pend[c] = pend[c];
        end
        return e;
    endfunction

    task automatic cycle(input logic [NCH-1:0] en, input bit sy, input bit we, input int ch,
                         input int dv, input bit md);
        en_i       = en;
        sync_i     = sy;
        cfg_we_i   = we;
        cfg_ch_i   = 2'(ch);
        cfg_div_i  = 16'(dv);
        cfg_mode_i = md;
        @(posedge clock_in_i);
        model_step();
        exp_q.push_back(model_out());
        @(negedge clock_in_i);
    endtask

    task automatic run(input int n, input logic [NCH-1:0] en);
        repeat (n) cycle(en, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock_in_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("clock_out", clock_out_o, e.out);
                chk("tick", tick_o, e.tick);
                chk("cfg_pending", cfg_pending_o, e.pend);
            end
        end
    end

    initial begin : stimulus
        reset_i = 1'b1; en_i = '0; sync_i = 0; cfg_we_i = 0; cfg_ch_i = 0;
        cfg_div_i = 0; cfg_mode_i = 0;
        model_reset();
        @(negedge clock_in_i);
        chk("reset_out", clock_out_o, '0);
        chk("reset_tick", tick_o, '0);
        chk("reset_pending", cfg_pending_o, '0);
        reset_i = 1'b0;

        // ch0 clock mode D=3: toggles every 4 edges, ticks at 4, 8, 12
        cycle(4'b0000, 0, 1, 0, 3, 0);
        run(14, 4'b0001);

        // ch1 strobe D=4, then D=0 (constant high once applied)
        cycle(4'b0000, 0, 1, 1, 4, 1);
        run(12, 4'b0011);
        cycle(4'b0011, 0, 1, 1, 0, 1);
        run(10, 4'b0011);

        // ch0 running D=3: write D=7 mid-period, period grows only after the boundary
        run(1, 4'b0001);
        cycle(4'b0001, 0, 1, 0, 7, 0);
        run(40, 4'b0001);

        // write landing on a terminal edge, clock->strobe
        for (int k = 0; k < 20 && rem[0] != 0; k++) run(1, 4'b0001);
        cycle(4'b0001, 0, 1, 0, 3, 1);
        run(24, 4'b0001);

        // phase alignment: D=2,3,5,7 then sync mid-run
        cycle(4'b0000, 0, 1, 0, 2, 0);
        cycle(4'b0000, 0, 1, 1, 3, 0);
        cycle(4'b0000, 0, 1, 2, 5, 0);
        cycle(4'b0000, 0, 1, 3, 7, 0);
        run(11, 4'b1111);
        cycle(4'b1111, 1, 0, 0, 0, 0);
        run(20, 4'b1111);

        // sync with a coincident write, and a pending write flushed by sync
        cycle(4'b1111, 0, 1, 2, 4, 1);
        cycle(4'b1111, 1, 1, 1, 6, 1);
        run(16, 4'b1111);

        // maximum ratio is legal
        cycle(4'b0111, 0, 1, 3, 16'hFFFF, 0);
        run(6, 4'b1111);

        // async reset between edges mid-period
        #2 reset_i = 1'b1;
        #1;
        chk("async_rst_out", clock_out_o, '0);
        chk("async_rst_tick", tick_o, '0);
        chk("async_rst_pending", cfg_pending_o, '0);
        @(negedge clock_in_i);
        reset_i = 1'b0;
        model_reset();
        run(8, 4'b1111);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] en;
            int dv;
            en = 4'($urandom | $urandom | $urandom);
            dv = ($urandom_range(0, 49) == 0) ? int'($urandom_range(200, 65535))
                                              : int'($urandom_range(0, 9));
            cycle(en, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, NCH - 1)), dv, 1'($urandom));
        end

        @(negedge clock_in_i);
        @(negedge clock_in_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
